lcd_refresh_ctrl: RTL and testbench

Sequencer and write-port arbiter for the 2x16 character display buffer. Periodically triggers the binary-to-LCD converter, latches the X/Y vs. R/theta display mode so it only changes between frames, and shares the 32-byte character-buffer write port between the converter and a status-message writer. Sits between the UI button logic, the converter and the character RAM feeding the LCD driver.

---
 rtl/lcd_refresh_ctrl.sv | 141 ++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_ctrl.sv
// Refresh sequencer and character-buffer write-port arbiter for the 2x16 LCD.
// Schedules converter frames, latches the display mode between frames and muxes buffer writes.
module lcd_refresh_ctrl #(
  parameter int unsigned REFRESH_DIV = 5000000,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       hold,
  output logic       conv_update,
  output logic       conv_magphase,
  input  logic       conv_we,
  input  logic [4:0] conv_addr,
  input  logic [7:0] conv_dat,
  input  logic       msg_req,
  output logic       msg_gnt,
  input  logic       msg_we,
  input  logic [4:0] msg_addr,
  input  logic [7:0] msg_dat,
  output logic       buf_we,
  output logic [4:0] buf_addr,
  output logic [7:0] buf_dat,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, CONV, MSG} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] wd_q;
  logic          tick_q;
  logic          toggle_q;
  logic          upd_q;
  logic          mp_q;
  logic          gnt_q;
  logic          we_q;
  logic [4:0]    addr_q;
  logic [7:0]    dat_q;
  logic          busy_q;
  logic          done_q;
  logic          terr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wd_q     <= '0;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
      upd_q    <= 1'b0;
      mp_q     <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (msg_req) begin
            gnt_q   <= 1'b1;
            state_q <= MSG;
          end else if (tick_q && !hold) begin
            // Strobe and new mode become visible together for the START cycle.
            upd_q   <= 1'b1;
            busy_q  <= 1'b1;
            tick_q  <= 1'b0;
            if (toggle_q) begin
              mp_q     <= ~mp_q;
              toggle_q <= 1'b0;
            end
            state_q <= START;
          end
        end
        START: begin
          wd_q    <= '0;
          state_q <= CONV;
        end
        CONV: begin
          wd_q <= wd_q + 1'b1;
          if (conv_we) begin
            we_q   <= 1'b1;
            addr_q <= conv_addr;
            dat_q  <= conv_dat;
          end
          if (conv_we && conv_addr == 5'd31) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wd_q == WD_MAX) begin
            terr_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        MSG: begin
          if (msg_we) begin
            we_q   <= 1'b1;
            addr_q <= msg_addr;
            dat_q  <= msg_dat;
          end
          if (!msg_req) begin
            gnt_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // New events override the clears above so none is lost at a START edge.
      if (cnt_q == CNT_MAX) tick_q <= 1'b1;
      if (mode_btn) toggle_q <= 1'b1;
    end
  end

  assign conv_update   = upd_q;
  assign conv_magphase = mp_q;
  assign msg_gnt       = gnt_q;
  assign buf_we        = we_q;
  assign buf_addr      = addr_q;
  assign buf_dat       = dat_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_lcd_refresh_ctrl;
  localparam int DIV = 100;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode_btn = 1'b0;
  logic       hold = 1'b0;
  logic       conv_update, conv_magphase;
  logic       conv_we = 1'b0;
  logic [4:0] conv_addr = '0;
  logic [7:0] conv_dat = '0;
  logic       msg_req = 1'b0;
  logic       msg_gnt;
  logic       msg_we = 1'b0;
  logic [4:0] msg_addr = '0;
  logic [7:0] msg_dat = '0;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_dat;
  logic       busy, frame_done, timeout_err;

  lcd_refresh_ctrl #(.REFRESH_DIV(DIV), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .hold(hold),
    .conv_update(conv_update), .conv_magphase(conv_magphase),
    .conv_we(conv_we), .conv_addr(conv_addr), .conv_dat(conv_dat),
    .msg_req(msg_req), .msg_gnt(msg_gnt), .msg_we(msg_we),
    .msg_addr(msg_addr), .msg_dat(msg_dat),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_dat(buf_dat),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;
  int n_upd = 0, n_done = 0, n_bufwe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference model: t = index of the clock edge since reset release;
  // a frame is described by the edge its START began (fstart).
  int   t = 0;
  int   fstart = -1;
  int   age;
  bit   tick_pend, tog, mp, gnt, terr;
  bit   e_upd, e_we, e_done;
  logic [4:0] e_addr;
  logic [7:0] e_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; fstart = -1; tick_pend = 0; tog = 0; mp = 0; gnt = 0; terr = 0;
      e_upd = 0; e_we = 0; e_done = 0; e_addr = '0; e_dat = '0;
    end else begin
      t++;
      e_upd = 0; e_we = 0; e_done = 0;
      if (fstart >= 0) begin
        age = t - fstart;
        if (age >= 2) begin
          if (conv_we) begin e_we = 1; e_addr = conv_addr; e_dat = conv_dat; end
          if (conv_we && conv_addr == 5'd31) begin e_done = 1; fstart = -1; end
          else if (age == TO + 1) begin terr = 1; fstart = -1; end
        end
      end else if (gnt) begin
        if (msg_we) begin e_we = 1; e_addr = msg_addr; e_dat = msg_dat; end
        if (!msg_req) gnt = 0;
      end else if (msg_req) begin
        gnt = 1;
      end else if (tick_pend && !hold) begin
        fstart = t; e_upd = 1; tick_pend = 0;
        if (tog) begin mp = !mp; tog = 0; end
      end
      if (t % DIV == 0) tick_pend = 1;
      if (mode_btn) tog = 1;
    end
  end

  always @(negedge clk) begin
    logic [19:0] a, e;
    a = {conv_update, conv_magphase, msg_gnt, buf_we, busy, frame_done, timeout_err,
         e_we ? buf_addr : 5'd0, e_we ? buf_dat : 8'd0};
    e = {e_upd, mp, gnt, e_we, (fstart >= 0), e_done, terr,
         e_we ? e_addr : 5'd0, e_we ? e_dat : 8'd0};
    chk($sformatf("cycle t=%0d", t), 32'(a), 32'(e));
    if (rst_n) begin
      if (conv_update) n_upd++;
      if (frame_done) n_done++;
      if (buf_we) n_bufwe++;
    end
  end

  // Converter model: writes addr 0..31 starting two cycles after the strobe.
  int cidx = -1;
  int stall_after = -1;
  bit junk_en = 0;

  always @(posedge clk) begin
    #1;
    conv_we = 1'b0;
    if (!rst_n) cidx = -1;
    else begin
      if (cidx >= 0) begin
        if (stall_after >= 0 && cidx > stall_after) cidx = -1;
        else begin
          conv_we = 1'b1; conv_addr = 5'(cidx); conv_dat = 8'(cidx * 5 + 1);
          cidx++;
          if (cidx == 32) cidx = -1;
        end
      end else if (junk_en) begin
        conv_we = 1'b1; conv_addr = 5'($urandom_range(30, 0)); conv_dat = 8'hEE;
      end
      if (conv_update) cidx = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 5000 && t < target; i++) step(1);
  endtask

  task automatic wait_upd(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(posedge clk); #1;
      if (conv_update) at = t;
    end
    if (at < 0) begin
      n_checks++;
      $display("FAIL wait_update: none within %0d cycles", budget);
    end
  endtask

  initial begin
    int a, u0, d0, w0, tt;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_outputs", 32'({conv_update, conv_magphase, msg_gnt, buf_we, buf_addr, buf_dat,
                              busy, frame_done, timeout_err}), 32'd0);
    #10 rst_n = 1'b1;

    wait_upd(200, a);
    chk("first_update_edge", a, 101);
    step_to(370);
    chk("frames_done", n_done, 3);
    chk("frame_buf_writes", n_bufwe, 96);
    chk("update_count", n_upd, 3);

    wait_upd(100, a);
    chk("update_period", a, 401);
    step(5);
    repeat (3) begin mode_btn = 1'b1; step(1); mode_btn = 1'b0; step(3); end
    chk("mode_held_in_frame", conv_magphase, 0);
    wait_upd(100, a);
    chk("mode_start_edge", a, 501);
    chk("mode_toggled_once", conv_magphase, 1);

    step_to(550);
    chk("gnt_before_req", msg_gnt, 0);
    u0 = n_upd; w0 = n_bufwe;
    msg_req = 1'b1; junk_en = 1'b1;
    step(1);
    chk("gnt_latency", msg_gnt, 1);
    for (int i = 0; i < 16; i++) begin
      msg_we = 1'b1; msg_addr = 5'(i); msg_dat = 8'(8'h80 + i); step(1);
    end
    msg_we = 1'b0;
    step_to(800);
    chk("no_update_in_grant", n_upd, u0);
    chk("msg_writes_only", n_bufwe - w0, 16);
    msg_req = 1'b0; junk_en = 1'b0;
    wait_upd(10, a);
    chk("start_after_release", a, 802);

    step_to(850);
    stall_after = 10; d0 = n_done;
    wait_upd(100, a);
    chk("stall_frame_start", a, 901);
    tt = -1;
    for (int i = 0; i < 100 && tt < 0; i++) begin step(1); if (timeout_err) tt = t; end
    chk("timeout_latency", tt - a, 65);
    chk("no_done_on_abort", n_done, d0);
    stall_after = -1;
    wait_upd(100, a);
    chk("start_after_abort", a, 1001);
    step(40);
    chk("done_after_abort", n_done, d0 + 1);
    chk("timeout_sticky", timeout_err, 1);

    step_to(1050);
    hold = 1'b1; u0 = n_upd;
    step_to(1350);
    chk("no_update_in_hold", n_upd, u0);
    hold = 1'b0;
    wait_upd(10, a);
    chk("hold_release_edge", a, 1351);
    step_to(1395);
    chk("one_frame_on_release", n_upd, u0 + 1);

    wait_upd(20, a);
    chk("pre_reset_start", a, 1401);
    tt = -1;
    for (int i = 0; i < 40 && tt < 0; i++) begin
      step(1);
      if (buf_we && buf_addr == 5'd15) tt = t;
    end
    chk("addr15_edge", tt, 1418);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midframe", 32'({conv_update, msg_gnt, buf_we, buf_addr, buf_dat,
                               busy, frame_done, timeout_err}), 32'd0);
    chk("reset_mode", conv_magphase, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_upd(200, a);
    chk("post_reset_start", a, 101);
    step(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
